// File: rtl/adc_report_sequencer_if.sv
// Byte-stream bundle between the ADC capture side, the report sequencer and the UART TX serializer.
// master = sequencer side, slave = the capture/UART side that drives samples and ready.
interface adc_report_sequencer_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              tx_ready;
    logic              busy;
    logic              frame_done;
    logic              dropped;

    modport master (
        input  sample, sample_valid, tx_ready,
        output tx_byte, tx_valid, busy, frame_done, dropped
    );

    modport slave (
        output sample, sample_valid, tx_ready,
        input  tx_byte, tx_valid, busy, frame_done, dropped
    );
endinterface

// File: rtl/adc_report_sequencer.sv
// Converts each ADC code to BCD with a sequential double-dabble and streams it out as an
// ASCII report frame ("d.ddd\n\r") over a valid/ready byte interface. One pending sample is buffered.
module adc_report_sequencer #(
    parameter int DATA_W   = 12,
    parameter int DIGITS   = 4,
    parameter int DP_AFTER = 1,
    parameter int EOL_CR   = 1
) (
    input  logic              clk,
    input  logic              reset,
    adc_report_sequencer_if.master bus
);
    localparam int     HAS_DP = (DP_AFTER > 0 && DP_AFTER < DIGITS) ? 1 : 0;
    localparam int     HAS_CR = (EOL_CR != 0) ? 1 : 0;
    localparam int     FLEN   = DIGITS + HAS_DP + 1 + HAS_CR;
    localparam int     BCD_W  = 4 * DIGITS;
    localparam int     CNT_W  = $clog2(DATA_W + 1);
    localparam int     IDX_W  = $clog2(FLEN + 1);
    localparam longint MAXDEC = longint'(10) ** DIGITS - 1;

    if (((longint'(1) << DATA_W) - 1) > MAXDEC) begin : g_range_err
        $error("adc_report_sequencer: DIGITS too small for DATA_W");
    end

    typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_EMIT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [DATA_W-1:0]  sh_q;
    logic [DATA_W-1:0]  pend_q;
    logic               pend_vld_q;
    logic               frame_done_q;
    logic               dropped_q;
    logic               last_hs;

    // One double-dabble iteration: correct every nibble >= 5, then shift the next code bit in.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd, input logic din);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
        return {adj[BCD_W-2:0], din};
    endfunction

    function automatic logic [7:0] frame_byte(input logic [IDX_W-1:0] idx, input logic [BCD_W-1:0] bcd);
        int         k;
        logic [7:0] b;
        k = int'(idx);
        b = 8'h0A;
        if (HAS_DP == 1 && k == DP_AFTER) begin
            b = 8'h2E;
        end else begin
            if (HAS_DP == 1 && k > DP_AFTER) k = k - 1;
            if (k < DIGITS)       b = {4'h3, bcd[(DIGITS-1-k)*4 +: 4]};
            else if (k == DIGITS) b = 8'h0A;
            else                  b = 8'h0D;
        end
        return b;
    endfunction

    assign last_hs = (state_q == S_EMIT) && bus.tx_ready && (idx_q == IDX_W'(FLEN - 1));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.sample_valid || pend_vld_q) state_d = S_CONVERT;
            S_CONVERT: if (cnt_q == CNT_W'(DATA_W - 1)) state_d = S_EMIT;
            S_EMIT:    if (last_hs) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.tx_valid   = (state_q == S_EMIT);
        bus.tx_byte    = (state_q == S_EMIT) ? frame_byte(idx_q, bcd_q) : 8'h00;
        bus.busy       = (state_q == S_CONVERT) || (state_q == S_EMIT);
        bus.frame_done = frame_done_q;
        bus.dropped    = dropped_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            bcd_q        <= '0;
            pend_vld_q   <= 1'b0;
            frame_done_q <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_done_q <= last_hs;
            dropped_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.sample_valid || pend_vld_q) begin
                        bcd_q      <= '0;
                        cnt_q      <= '0;
                        pend_vld_q <= 1'b0;
                    end
                    // A fresh sample wins over a stale pending one.
                    if (bus.sample_valid && pend_vld_q) dropped_q <= 1'b1;
                end
                S_CONVERT: begin
                    bcd_q <= dabble_step(bcd_q, sh_q[DATA_W-1]);
                    cnt_q <= cnt_q + CNT_W'(1);
                    idx_q <= '0;
                end
                S_EMIT: begin
                    if (bus.tx_ready) idx_q <= idx_q + IDX_W'(1);
                end
                default: ;
            endcase
            if (state_q != S_IDLE && bus.sample_valid) begin
                pend_vld_q <= 1'b1;
                if (pend_vld_q) dropped_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE) begin
            sh_q <= bus.sample_valid ? bus.sample : pend_q;
        end else if (state_q == S_CONVERT) begin
            sh_q <= sh_q << 1;
        end
        if (state_q != S_IDLE && bus.sample_valid) pend_q <= bus.sample;
    end
endmodule

// File: tb/tb_adc_report_sequencer.sv
// Directed bench: table of samples with hand-computed ASCII frames, plus sequences for
// pending-slot overwrite, mid-frame reset and the no-dot/no-CR variant.
module tb_adc_report_sequencer;
    typedef struct packed {
        logic [11:0] s;
        logic        rnd;
        logic [55:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] sample = '0;
    logic        sample_valid = 1'b0;
    logic        tx_ready = 1'b1;
    logic        sel = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          done_cnt = 0;
    int          drop_cnt = 0;
    vec_t        vecs[5];

    always #5 clk = ~clk;

    adc_report_sequencer_if #(.DATA_W(12)) if0 ();
    adc_report_sequencer_if #(.DATA_W(12)) if6 ();

    assign if0.sample       = sample;
    assign if0.sample_valid = sample_valid;
    assign if0.tx_ready     = tx_ready;
    assign if6.sample       = sample;
    assign if6.sample_valid = sample_valid;
    assign if6.tx_ready     = tx_ready;

    adc_report_sequencer #(.DATA_W(12), .DIGITS(4), .DP_AFTER(1), .EOL_CR(1)) dut (
        .clk(clk), .reset(reset), .bus(if0.master)
    );
    adc_report_sequencer #(.DATA_W(12), .DIGITS(4), .DP_AFTER(0), .EOL_CR(0)) dut6 (
        .clk(clk), .reset(reset), .bus(if6.master)
    );

    wire [7:0] mon_byte  = sel ? if6.tx_byte  : if0.tx_byte;
    wire       mon_valid = sel ? if6.tx_valid : if0.tx_valid;

    always @(posedge clk) begin
        if (if0.frame_done) done_cnt++;
        if (if0.dropped)    drop_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send_sample(input logic [11:0] s);
        @(negedge clk);
        sample       = s;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Entered at cycle 1 after the sample strobe; returns at the cycle after the last handshake.
    task automatic run_frame(input string name, input logic [55:0] exp, input int len,
                             input logic rnd, output int first_cyc);
        int         cyc = 1;
        int         n = 0;
        logic       hold = 1'b0;
        logic [7:0] prev = 8'h00;
        logic       r;
        first_cyc = -1;
        while (n < len && cyc < 300) begin
            if (hold) chk({name, "_hold"}, {23'd0, mon_valid, mon_byte}, {23'd0, 1'b1, prev});
            if (mon_valid) begin
                r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                tx_ready = r;
                if (first_cyc < 0) first_cyc = cyc;
                if (r) begin
                    chk($sformatf("%s_b%0d", name, n), {24'd0, mon_byte}, {24'd0, exp[55-8*n -: 8]});
                    n++;
                end
                hold = !r;
                prev = mon_byte;
            end else begin
                tx_ready = 1'b1;
                hold     = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        tx_ready = 1'b1;
        if (n < len) chk({name, "_timeout"}, n, len);
    endtask

    initial begin
        int first;
        int d0;
        vecs[0] = '{12'hFFF, 1'b0, 56'h34_2E_30_39_35_0A_0D};
        vecs[1] = '{12'h000, 1'b0, 56'h30_2E_30_30_30_0A_0D};
        vecs[2] = '{12'h3E8, 1'b0, 56'h31_2E_30_30_30_0A_0D};
        vecs[3] = '{12'h07B, 1'b1, 56'h30_2E_31_32_33_0A_0D};
        vecs[4] = '{12'h9C4, 1'b1, 56'h32_2E_35_30_30_0A_0D};

        repeat (3) @(negedge clk);
        chk("rst_tx_valid", {31'd0, if0.tx_valid}, 32'd0);
        chk("rst_busy", {31'd0, if0.busy}, 32'd0);
        chk("rst_tx_byte", {24'd0, if0.tx_byte}, 32'd0);
        chk("rst_frame_done", {31'd0, if0.frame_done}, 32'd0);
        chk("rst_dropped", {31'd0, if0.dropped}, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) begin
            d0 = done_cnt;
            send_sample(vecs[i].s);
            run_frame($sformatf("vec%0d", i), vecs[i].exp, 7, vecs[i].rnd, first);
            if (i == 0) chk("latency", first, 13);
            chk($sformatf("vec%0d_done", i), {31'd0, if0.frame_done}, 32'd1);
            chk($sformatf("vec%0d_idle", i), {30'd0, if0.busy, if0.tx_valid}, 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_done_once", i), done_cnt - d0, 1);
        end

        // Pending slot: 200 then 300 arrive during the 100 frame; 300 overwrites 200.
        d0 = drop_cnt;
        send_sample(12'd100);
        sample = 12'd200; sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        @(negedge clk); sample = 12'd300; sample_valid = 1'b1;
        @(negedge clk); sample_valid = 1'b0;
        run_frame("pend_a", 56'h30_2E_31_30_30_0A_0D, 7, 1'b0, first);
        chk("pend_gap_idle", {31'd0, if0.busy}, 32'd0);
        @(negedge clk);
        chk("pend_restart", {31'd0, if0.busy}, 32'd1);
        run_frame("pend_b", 56'h30_2E_33_30_30_0A_0D, 7, 1'b0, first);
        @(negedge clk);
        chk("pend_dropped", drop_cnt - d0, 1);

        // Reset while byte 3 is on the bus aborts the frame without frame_done.
        d0 = done_cnt;
        send_sample(12'h9C4);
        run_frame("abort", 56'h32_2E_35_00_00_00_00, 3, 1'b0, first);
        chk("abort_at_b3", {23'd0, if0.tx_valid, if0.tx_byte}, {23'd0, 1'b1, 8'h30});
        reset = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; tx_ready = 1'b1;
        chk("abort_state", {22'd0, if0.busy, if0.tx_valid, if0.tx_byte}, 32'd0);
        @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        send_sample(12'h000);
        run_frame("fresh", 56'h30_2E_30_30_30_0A_0D, 7, 1'b0, first);
        chk("fresh_done", {31'd0, if0.frame_done}, 32'd1);

        // Variant without decimal point and without CR: five bytes.
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sel = 1'b1;
        send_sample(12'hFFF);
        run_frame("nodp", 56'h34_30_39_35_0A_00_00, 5, 1'b0, first);
        chk("nodp_end", {30'd0, if6.tx_valid, if6.frame_done}, 32'd1);
        sel = 1'b0;

        repeat (20) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
